// File: rtl/pc_cache_mem_pkg.sv
// pc_cache_mem_pkg: word width and default parameter values shared by the PC/memory slice.
// Revision 1.0 - initial release
`default_nettype none

package pc_cache_mem_pkg;
  localparam int          WORD_W           = 32;
  localparam int          DEPTH_DEFAULT    = 1024;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

`default_nettype wire

// File: rtl/cache_mem.sv
// cache_mem: word-addressed RAM with byte addressing, combinational read, synchronous write.
// Revision 1.0 - initial release
`default_nettype none

module cache_mem
  import pc_cache_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  logic [IDX_W-1:0]  index;
  logic [WORD_W-1:0] upper;
  logic              in_range;

  // Any set bit above the word index means the access falls outside the array.
  assign upper    = address >> (IDX_W + 2);
  assign in_range = (upper == '0);
  assign index    = address[IDX_W+1:2];

  always_comb begin
    read_data = '0;
    if (MemRead && in_range) begin
      read_data = mem[index];
    end
  end

  always_ff @(posedge clk) begin
    if (MemWrite && in_range) begin
      mem[index] <= write_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc.sv
// pc: program counter register with synchronous reset and load enable.
// Revision 1.0 - initial release
`default_nettype none

module pc
  import pc_cache_mem_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic [WORD_W-1:0] next_pc,
  output logic [WORD_W-1:0] pc_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_PC;
    end else if (PCWrite) begin
      pc_out <= next_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_cache_mem.sv
// pc_cache_mem: PC register and shared instruction/data memory with address select.
// Revision 1.0 - initial release
`default_nettype none

module pc_cache_mem
  import pc_cache_mem_pkg::*;
#(
  parameter int                DEPTH    = DEPTH_DEFAULT,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              Inst_Data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] next_pc,
  input  logic [WORD_W-1:0] data_y,
  input  logic [WORD_W-1:0] data_z,
  output logic [WORD_W-1:0] current_pc,
  output logic [WORD_W-1:0] instr_data_out
);

  logic [WORD_W-1:0] address;

  assign address = Inst_Data ? data_z : current_pc;

  pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .PCWrite (PCWrite),
    .next_pc (next_pc),
    .pc_out  (current_pc)
  );

  // The memory has no reset port, so writes are held off here while reset is high.
  cache_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk        (clk),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite & ~reset),
    .address    (address),
    .write_data (data_y),
    .read_data  (instr_data_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_cache_mem.sv
// tb_pc_cache_mem: scenario tasks with a queue of expected values for pc_cache_mem.
// Revision 1.0 - initial release
`default_nettype none

module tb_pc_cache_mem;
  localparam int          DEPTH = 128;
  localparam logic [31:0] OOR   = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset, PCWrite, Inst_Data, MemRead, MemWrite;
  logic [31:0] next_pc, data_y, data_z;
  logic [31:0] current_pc, instr_data_out;

  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          checks = 0;
  int          errors = 0;

  pc_cache_mem #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PCWrite        (PCWrite),
    .Inst_Data      (Inst_Data),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .next_pc        (next_pc),
    .data_y         (data_y),
    .data_z         (data_z),
    .current_pc     (current_pc),
    .instr_data_out (instr_data_out)
  );

  always #5 clk = ~clk;

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; PCWrite = 1'b1; next_pc = 32'h40; MemRead = 1'b0;
    exp_q.push_back(32'h0);
    edge_settle();
    checks++; e = exp_q.pop_front();
    if (current_pc !== e) begin errors++; $display("FAIL reset_pc got %h exp %h", current_pc, e); end
    exp_q.push_back(32'h0);
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL reset_rd got %h exp %h", instr_data_out, e); end
  endtask

  task automatic test_pc_load();
    @(negedge clk);
    reset = 1'b0; PCWrite = 1'b0; next_pc = 32'h8;
    exp_q.push_back(32'h0);
    edge_settle();
    checks++; e = exp_q.pop_front();
    if (current_pc !== e) begin errors++; $display("FAIL pc_hold got %h exp %h", current_pc, e); end
    @(negedge clk);
    PCWrite = 1'b1;
    exp_q.push_back(32'h8);
    edge_settle();
    checks++; e = exp_q.pop_front();
    if (current_pc !== e) begin errors++; $display("FAIL pc_load got %h exp %h", current_pc, e); end
    @(negedge clk);
    PCWrite = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    dut.u_mem.mem[0] = 32'h2002000A;
    dut.u_mem.mem[1] = 32'h20030005;
    PCWrite = 1'b1; next_pc = 32'h4;
    edge_settle();
    @(negedge clk);
    PCWrite = 1'b0; Inst_Data = 1'b0; MemRead = 1'b1;
    exp_q.push_back(32'h20030005);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL fetch_pc4 got %h exp %h", instr_data_out, e); end
    PCWrite = 1'b1; next_pc = 32'h0;
    exp_q.push_back(32'h2002000A);
    edge_settle();
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL fetch_pc0 got %h exp %h", instr_data_out, e); end
    @(negedge clk);
    PCWrite = 1'b0;
  endtask

  task automatic test_data_rw();
    @(negedge clk);
    Inst_Data = 1'b1; data_z = 32'h100; data_y = 32'hDEADBEEF; MemWrite = 1'b1; MemRead = 1'b0;
    edge_settle();
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL data_rd got %h exp %h", instr_data_out, e); end
    data_z = 32'h103;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL data_rd_unaligned got %h exp %h", instr_data_out, e); end
  endtask

  task automatic test_boundaries();
    @(negedge clk);
    MemRead = 1'b0; data_z = 32'h100;
    exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL memread_off got %h exp %h", instr_data_out, e); end
    MemRead = 1'b1; data_z = OOR;
    exp_q.push_back(32'h0);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL oor_read got %h exp %h", instr_data_out, e); end
    MemWrite = 1'b1; data_y = 32'h12345678;
    edge_settle();
    @(negedge clk);
    MemWrite = 1'b0; data_z = 32'h0;
    exp_q.push_back(32'h2002000A);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL oor_write_alias got %h exp %h", instr_data_out, e); end
    dut.u_mem.mem[65] = 32'h11111111;
    reset = 1'b1; MemWrite = 1'b1; data_z = 32'h104; data_y = 32'hCAFEF00D;
    exp_q.push_back(32'h11111111);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL read_in_reset got %h exp %h", instr_data_out, e); end
    edge_settle();
    @(negedge clk);
    reset = 1'b0; MemWrite = 1'b0;
    exp_q.push_back(32'h11111111);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL write_in_reset got %h exp %h", instr_data_out, e); end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    dut.u_mem.mem[66] = 32'hAAAA0001;
    Inst_Data = 1'b1; data_z = 32'h108; MemRead = 1'b1; MemWrite = 1'b1; data_y = 32'hBBBB0002;
    exp_q.push_back(32'hAAAA0001);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL rdw_old got %h exp %h", instr_data_out, e); end
    exp_q.push_back(32'hBBBB0002);
    edge_settle();
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL rdw_new got %h exp %h", instr_data_out, e); end
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Write through the fetch address while the PC is updated on the same edge.
    @(negedge clk);
    PCWrite = 1'b1; next_pc = 32'h10C; Inst_Data = 1'b0;
    edge_settle();
    @(negedge clk);
    next_pc = 32'h110; MemWrite = 1'b1; data_y = 32'h5A5A1234;
    exp_q.push_back(32'h110);
    exp_q.push_back(32'h5A5A1234);
    edge_settle();
    checks++; e = exp_q.pop_front();
    if (current_pc !== e) begin errors++; $display("FAIL b2b_pc got %h exp %h", current_pc, e); end
    @(negedge clk);
    PCWrite = 1'b0; MemWrite = 1'b0; Inst_Data = 1'b1; data_z = 32'h10C;
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL b2b_mem got %h exp %h", instr_data_out, e); end
  endtask

  task automatic test_reset_persist();
    @(negedge clk);
    reset = 1'b1; PCWrite = 1'b1; next_pc = 32'h20;
    exp_q.push_back(32'h0);
    edge_settle();
    checks++; e = exp_q.pop_front();
    if (current_pc !== e) begin errors++; $display("FAIL persist_pc got %h exp %h", current_pc, e); end
    @(negedge clk);
    reset = 1'b0; PCWrite = 1'b0; Inst_Data = 1'b0; MemRead = 1'b1;
    exp_q.push_back(32'h2002000A);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL persist_w0 got %h exp %h", instr_data_out, e); end
    Inst_Data = 1'b1; data_z = 32'h4;
    exp_q.push_back(32'h20030005);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL persist_w1 got %h exp %h", instr_data_out, e); end
    data_z = 32'h100;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; e = exp_q.pop_front();
    if (instr_data_out !== e) begin errors++; $display("FAIL persist_w64 got %h exp %h", instr_data_out, e); end
  endtask

  initial begin
    reset = 1'b1; PCWrite = 1'b0; Inst_Data = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    next_pc = '0; data_y = '0; data_z = '0;
    test_reset();
    test_pc_load();
    test_fetch();
    test_data_rw();
    test_boundaries();
    test_read_during_write();
    test_back_to_back();
    test_reset_persist();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_cache_mem.md
PC_CACHE_MEM -- requirements
Module: pc_cache_mem

Interface
REQ-001 Parameter DEPTH SHALL default to 1024 and give the number of 32-bit memory words (power of two, at least 4).
REQ-002 Parameter RESET_PC SHALL default to 32'h0000_0000 and give the PC value after reset.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset SHALL be synchronous and active-high.
REQ-005 PCWrite  input  1  PC load enable.
REQ-006 Inst_Data  input  1  address select: 0 selects the PC (instruction fetch), 1 selects data_z (data access).
REQ-007 MemRead  input  1  memory read enable.
REQ-008 MemWrite  input  1  memory write enable.
REQ-009 next_pc  input  32  value loaded into the PC.
REQ-010 data_y  input  32  memory write data.
REQ-011 data_z  input  32  data-access byte address.
REQ-012 current_pc  output  32  current PC register value.
REQ-013 instr_data_out  output  32  instruction or data word read from memory.

Function
REQ-014 The PC register SHALL load next_pc on a rising edge when PCWrite=1 and reset=0, and SHALL hold otherwise.
REQ-015 current_pc SHALL equal the PC register with no added combinational logic.
REQ-016 The effective address SHALL be data_z when Inst_Data=1 and the PC register value when Inst_Data=0.
REQ-017 The address SHALL be a byte address: the word index is address[log2(DEPTH)+1:2] and bits [1:0] are ignored.
REQ-018 Any address with a nonzero bit above log2(DEPTH)+1 SHALL be out of range.
REQ-019 Reads SHALL be combinational: with MemRead=1 and an in-range address, instr_data_out SHALL equal mem[word index] in the same cycle.
REQ-020 instr_data_out SHALL be 32'h0 when MemRead=0 or when the address is out of range.
REQ-021 With MemWrite=1, reset=0 and an in-range address, data_y SHALL be written to mem[word index] on the rising edge.
REQ-022 Out-of-range writes SHALL be ignored with no aliasing.
REQ-023 When MemRead and MemWrite are both 1 at the same address, instr_data_out SHALL show the old word until the edge and the new word after it.
REQ-024 The PC update and a memory write in the same cycle SHALL both use pre-edge values, so a fetch address taken from the PC is the value before the update.

Reset
REQ-025 While reset=1 at a rising edge, the PC SHALL become RESET_PC regardless of PCWrite.
REQ-026 While reset=1, memory writes SHALL be suppressed.
REQ-027 Reset SHALL NOT clear memory contents; preloaded contents SHALL persist across reset.
REQ-028 instr_data_out SHALL remain combinational during reset and follow REQ-019 and REQ-020.

Structure
REQ-029 Sub-module pc SHALL contain the PC register (ports clk, reset, PCWrite, next_pc, pc_out).
REQ-030 Sub-module cache_mem SHALL contain the memory (ports clk, MemRead, MemWrite, address, write_data, read_data).
REQ-031 The cache_mem storage SHALL be an unpacked array named mem of 32-bit words [0:DEPTH-1], so testbenches can preload it with $readmemh via the hierarchical path <instance>.mem.
REQ-032 The top level SHALL contain only the address multiplexer and the two instances.
REQ-033 No shared package is required; if one is used, it SHALL hold only the word width (32) and the DEPTH/RESET_PC defaults.

Verification
REQ-034 Reset: assert reset for 1 cycle with PCWrite=1 and next_pc=32'h40 -> current_pc=32'h0 after the edge.
REQ-035 PC hold/load: PCWrite=0 with next_pc=32'h8 -> current_pc stays 0; then PCWrite=1 -> current_pc=32'h8 next cycle.
REQ-036 Fetch: preload mem[0]=32'h2002000A and mem[1]=32'h20030005; with Inst_Data=0, MemRead=1 and PC=4 -> instr_data_out=32'h20030005 combinationally.
REQ-037 Data write/read: Inst_Data=1, data_z=32'h100, data_y=32'hDEADBEEF, MemWrite=1 for one edge, then MemRead=1 -> instr_data_out=32'hDEADBEEF; data_z=32'h103 returns the same word.
REQ-038 Boundaries: MemRead=0 -> instr_data_out=0; data_z=DEPTH*4 -> read 0 and a write there leaves mem[0] unchanged; MemWrite=1 during reset -> target word unchanged.
REQ-039 Read-during-write: same address, old word visible before the edge and new word after it; preloaded words unchanged after a mid-run reset.
